gpio_ctrl: RTL



---
 rtl/gpio_pkg.sv | 10 +
 rtl/gpio_chan.sv | 51 +++++
 rtl/gpio_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and edge-mode encodings shared by the GPIO controller
package gpio_pkg;
  localparam logic [1:0] REG_GPI = 2'd0;
  localparam logic [1:0] REG_GPO = 2'd1;
  localparam logic [1:0] REG_IE  = 2'd2;
  localparam logic [1:0] REG_IS  = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
endpackage

// File: rtl/gpio_chan.sv
// gpio_chan: one channel's input synchroniser, edge detector and GPO/IE/IS registers
module gpio_chan
  import gpio_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            EDGE_MODE = EDGE_BOTH,
  parameter logic [DW-1:0] GPO_RST   = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [1:0]    reg_i,
  input  logic [DW-1:0] wd_i,
  input  logic [DW-1:0] gpi_i,
  input  logic          evt_en_i,
  output logic [DW-1:0] rd_o,
  output logic [DW-1:0] gpo_o,
  output logic          irq_o
);
  logic [DW-1:0] s1_q, s2_q, prev_q, gpo_q, gpo_d, ie_q, ie_d, is_q, is_d;
  logic [DW-1:0] rise, fall, evt;
  always_comb begin
    rise  = s2_q & ~prev_q;
    fall  = ~s2_q & prev_q;
    evt   = evt_en_i ? (EDGE_MODE == EDGE_RISE ? rise : EDGE_MODE == EDGE_FALL ? fall : rise | fall) : '0;
    gpo_d = (we_i && reg_i == REG_GPO) ? wd_i : gpo_q;
    ie_d  = (we_i && reg_i == REG_IE) ? wd_i : ie_q;
    // a fresh event outranks a simultaneous write-1-to-clear of the same bit
    is_d  = evt | (is_q & ~((we_i && reg_i == REG_IS) ? wd_i : '0));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      gpo_q  <= GPO_RST;
      ie_q   <= '0;
      is_q   <= '0;
    end else begin
      s1_q   <= gpi_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      gpo_q  <= gpo_d;
      ie_q   <= ie_d;
      is_q   <= is_d;
    end
  end
  assign rd_o  = reg_i == REG_GPI ? s2_q : reg_i == REG_GPO ? gpo_q : reg_i == REG_IE ? ie_q : is_q;
  assign gpo_o = gpo_q;
  assign irq_o = |(is_q & ie_q);
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped multi-channel GPIO with synchronised inputs,
// edge-triggered sticky interrupt status and a registered IRQ line
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int            DW        = 32,
  parameter int            NCH       = 2,
  parameter int            AW        = $clog2(NCH) + 2,
  parameter int            EDGE_MODE = EDGE_BOTH,
  parameter logic [DW-1:0] GPO_RST   = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [AW-1:0]     A,
  input  logic [DW-1:0]     WD,
  output logic [DW-1:0]     RD,
  input  logic [NCH*DW-1:0] GPI,
  output logic [NCH*DW-1:0] GPO,
  output logic              IRQ
);
  logic [AW-1:0]  ch;
  logic [1:0]     cnt_q, cnt_d;
  logic           irq_q, irq_d;
  logic [NCH-1:0] irq_v;
  logic [DW-1:0]  rd_v [NCH];
  assign ch = A >> 2;
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    gpio_chan #(
      .DW       (DW),
      .EDGE_MODE(EDGE_MODE),
      .GPO_RST  (GPO_RST)
    ) u_chan (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .we_i    (WE && ch == AW'(g)),
      .reg_i   (A[1:0]),
      .wd_i    (WD),
      .gpi_i   (GPI[g*DW +: DW]),
      .evt_en_i(cnt_q == 2'd3),
      .rd_o    (rd_v[g]),
      .gpo_o   (GPO[g*DW +: DW]),
      .irq_o   (irq_v[g])
    );
  end
  // warm-up keeps inputs already high at reset release from posting events
  always_comb begin
    cnt_d = cnt_q == 2'd3 ? cnt_q : cnt_q + 2'd1;
    irq_d = |irq_v;
    RD    = '0;
    for (int c = 0; c < NCH; c++) RD = ch == AW'(c) ? rd_v[c] : RD;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end
  assign IRQ = irq_q;
endmodule
